rm_lane_tracker: RTL and testbench

Consumer end of the runtime-monitor event interface. Takes one `lane_ctrl` stream per event detector (probe pulse, lane index, lane reset) and runs an independent per-lane sequence state machine. A lane matches when events 0..NUM_EVENTS-1 fire in order. It raises a violation when the next expected event does not arrive within a programmable window. Sits after the bank of event detectors in the runtime-monitor path and feeds match/violation pulses to the monitor status/interrupt logic.

---
 rtl/ariane_pkg.sv | 18 +
 rtl/rm_lane_fsm.sv | 110 +++++++++++
 rtl/rm_lane_tracker.sv | 81 ++++++++
 tb/tb_rm_lane_tracker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared core types; this slice carries the runtime-monitor lane types.
// lane_ctrl is the per-event detector bundle, rm_lane_state_e the lane FSM.
package ariane_pkg;

  localparam int unsigned RM_LANE_W = 3;

  typedef struct packed {
    logic                 probe_val;
    logic [RM_LANE_W-1:0] lane;
    logic                 reset_lane;
  } lane_ctrl;

  typedef enum logic {
    RM_LANE_IDLE,
    RM_LANE_ACTIVE
  } rm_lane_state_e;

endpackage

// File: rtl/rm_lane_fsm.sv
// Per-lane sequence tracker: follows events 0..NUM_EVENTS-1 in order.
// Ports: hit_i/reset_i per-event vectors for this lane, enable_i, timeout_i;
// busy_o/match_o/violation_o registered, match_nxt_o feeds the match counter.
module rm_lane_fsm
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned TIMEOUT_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [TIMEOUT_W-1:0]  timeout_i,
  input  logic [NUM_EVENTS-1:0] hit_i,
  input  logic [NUM_EVENTS-1:0] reset_i,
  output logic                  busy_o,
  output logic                  match_o,
  output logic                  violation_o,
  output logic                  match_nxt_o
);

  localparam int unsigned STEP_W =
    (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam logic [STEP_W-1:0] LAST =
    STEP_W'(NUM_EVENTS - 1);

  rm_lane_state_e       state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 match_q, match_d;
  logic                 viol_q, viol_d;
  logic [TIMEOUT_W:0]   timer_inc;
  logic                 expire;

  // Widened so a saturated timer never aliases a programmed window.
  assign timer_inc = {1'b0, timer_q} + 1'b1;
  assign expire = (timeout_i != '0) &&
                  (timer_inc == {1'b0, timeout_i});

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    timer_d = timer_q;
    match_d = 1'b0;
    viol_d  = 1'b0;
    if (!enable_i || (|reset_i)) begin
      state_d = RM_LANE_IDLE;
      step_d  = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        RM_LANE_IDLE: begin
          if (hit_i[0]) begin
            if (NUM_EVENTS == 1) begin
              match_d = 1'b1;
            end else begin
              state_d = RM_LANE_ACTIVE;
              step_d  = STEP_W'(1);
              timer_d = '0;
            end
          end
        end
        RM_LANE_ACTIVE: begin
          if (hit_i[step_q]) begin
            timer_d = '0;
            if (step_q == LAST) begin
              match_d = 1'b1;
              state_d = RM_LANE_IDLE;
              step_d  = '0;
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end else if (expire) begin
            viol_d  = 1'b1;
            state_d = RM_LANE_IDLE;
            step_d  = '0;
            timer_d = '0;
          end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = RM_LANE_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RM_LANE_IDLE;
      step_q  <= '0;
      timer_q <= '0;
      match_q <= 1'b0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      timer_q <= timer_d;
      match_q <= match_d;
      viol_q  <= viol_d;
    end
  end

  assign busy_o      = (state_q == RM_LANE_ACTIVE);
  assign match_o     = match_q;
  assign violation_o = viol_q;
  assign match_nxt_o = match_d;

endmodule

// File: rtl/rm_lane_tracker.sv
// Runtime-monitor lane tracker: decodes per-event lane_ctrl into lanes.
// Ports: enable_i, timeout_i, lane_cnt_i in; busy_o, match_o, violation_o, match_count_o out.
module rm_lane_tracker
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned NUM_LANES  = 5,
  parameter int unsigned TIMEOUT_W  = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            enable_i,
  input  logic [TIMEOUT_W-1:0]            timeout_i,
  input  lane_ctrl [NUM_EVENTS-1:0]       lane_cnt_i,
  output logic [NUM_LANES-1:0]            busy_o,
  output logic [NUM_LANES-1:0]            match_o,
  output logic [NUM_LANES-1:0]            violation_o,
  output logic [CNT_W-1:0]                match_count_o
);

  localparam int unsigned POP_W = $clog2(NUM_LANES + 1);

  logic [NUM_EVENTS-1:0] hit   [NUM_LANES];
  logic [NUM_EVENTS-1:0] rst_v [NUM_LANES];
  logic [NUM_LANES-1:0]  match_nxt;
  logic [POP_W-1:0]      pop;
  logic [CNT_W:0]        sum;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Lane fields beyond NUM_LANES-1 match no lane and drop out here.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int k = 0; k < NUM_EVENTS; k++) begin
        hit[l][k] = lane_cnt_i[k].probe_val &&
                    (lane_cnt_i[k].lane == RM_LANE_W'(l));
        rst_v[l][k] = lane_cnt_i[k].reset_lane &&
                      (lane_cnt_i[k].lane == RM_LANE_W'(l));
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rm_lane_fsm #(
      .NUM_EVENTS (NUM_EVENTS),
      .TIMEOUT_W  (TIMEOUT_W)
    ) u_fsm (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .enable_i    (enable_i),
      .timeout_i   (timeout_i),
      .hit_i       (hit[g]),
      .reset_i     (rst_v[g]),
      .busy_o      (busy_o[g]),
      .match_o     (match_o[g]),
      .violation_o (violation_o[g]),
      .match_nxt_o (match_nxt[g])
    );
  end

  always_comb begin
    pop = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      pop = pop + POP_W'(match_nxt[l]);
    end
  end

  assign sum   = {1'b0, cnt_q} + (CNT_W+1)'(pop);
  assign cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count_o = cnt_q;

endmodule

// File: tb/tb_rm_lane_tracker.sv
// Bench for rm_lane_tracker: directed steps plus random traffic,
// checked against a lane-level behavioural model.
module tb_rm_lane_tracker;
  import ariane_pkg::*;

  localparam int NE = 4;
  localparam int NL = 5;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           enable_i = 1'b0;
  logic [7:0]     timeout_i = '0;
  lane_ctrl [NE-1:0] lc = '0;
  logic [NL-1:0]  busy_o, match_o, violation_o;
  logic [15:0]    match_count_o;

  int total = 0;
  int passed = 0;

  bit          m_act [NL];
  int          m_step [NL];
  int          m_tim [NL];
  logic [NL-1:0] m_match, m_viol;
  int          m_cnt;

  rm_lane_tracker dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .timeout_i     (timeout_i),
    .lane_cnt_i    (lc),
    .busy_o        (busy_o),
    .match_o       (match_o),
    .violation_o   (violation_o),
    .match_count_o (match_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic m_clear();
    for (int l = 0; l < NL; l++) begin
      m_act[l] = 0; m_step[l] = 0; m_tim[l] = 0;
    end
    m_match = '0; m_viol = '0;
  endtask

  task automatic m_edge();
    bit h [NE];
    bit r;
    int pop = 0;
    m_match = '0; m_viol = '0;
    for (int l = 0; l < NL; l++) begin
      r = 0;
      for (int k = 0; k < NE; k++) begin
        h[k] = lc[k].probe_val && (int'(lc[k].lane) == l);
        if (lc[k].reset_lane && int'(lc[k].lane) == l) r = 1;
      end
      if (!enable_i || r) begin
        m_act[l] = 0; m_step[l] = 0; m_tim[l] = 0;
      end else if (!m_act[l]) begin
        if (h[0]) begin
          m_act[l] = 1; m_step[l] = 1; m_tim[l] = 0;
        end
      end else if (h[m_step[l]]) begin
        m_tim[l] = 0;
        if (m_step[l] == NE-1) begin
          m_match[l] = 1; pop++;
          m_act[l] = 0; m_step[l] = 0;
        end else m_step[l]++;
      end else if (timeout_i != 0 &&
                   m_tim[l] + 1 == int'(timeout_i)) begin
        m_viol[l] = 1;
        m_act[l] = 0; m_step[l] = 0; m_tim[l] = 0;
      end else if (m_tim[l] < 255) m_tim[l]++;
    end
    m_cnt = m_cnt + pop;
    if (m_cnt > 16'hFFFF) m_cnt = 16'hFFFF;
  endtask

  task automatic check_all();
    logic [NL-1:0] mb;
    for (int l = 0; l < NL; l++) mb[l] = m_act[l];
    chk("busy", 32'(busy_o), 32'(mb));
    chk("match", 32'(match_o), 32'(m_match));
    chk("viol", 32'(violation_o), 32'(m_viol));
    chk("count", 32'(match_count_o), 32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk_i);
    m_edge();
    #1;
    check_all();
    @(negedge clk_i);
    lc = '0;
  endtask

  task automatic ev(int k, int l, bit p = 1, bit r = 0);
    lc[k].probe_val  = p;
    lc[k].lane       = 3'(l);
    lc[k].reset_lane = r;
  endtask

  task automatic seq(int l);
    for (int k = 0; k < NE; k++) begin
      ev(k, l);
      tick();
    end
  endtask

  initial begin
    m_clear();
    m_cnt = 0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_cnt", 32'(match_count_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    enable_i = 1'b1;
    timeout_i = 8'd0;
    tick();

    // in-order sequence on lane 2
    seq(2);
    chk("seq_match", 32'(match_o), 32'h04);
    chk("seq_cnt", 32'(match_count_o), 1);
    tick();
    chk("seq_pulse", 32'(match_o), 0);

    // out-of-order on lane 1
    ev(0, 1); tick();
    ev(2, 1); tick();
    ev(1, 1); tick();
    ev(2, 1); tick();
    ev(3, 1); tick();
    chk("ooo_match", 32'(match_o), 32'h02);
    chk("ooo_cnt", 32'(match_count_o), 2);

    // timeout window 3 on lane 0
    timeout_i = 8'd3;
    ev(0, 0); tick();
    tick(); tick(); tick();
    chk("to_viol", 32'(violation_o), 32'h01);
    chk("to_busy", 32'(busy_o[0]), 0);
    ev(0, 0); tick();
    tick(); tick();
    ev(1, 0); tick();
    chk("adv_noviol", 32'(violation_o), 0);
    chk("adv_busy", 32'(busy_o[0]), 1);
    tick(); tick(); tick();
    chk("to2_viol", 32'(violation_o), 32'h01);

    // lane 4 collisions
    timeout_i = 8'd0;
    ev(0, 4); tick();
    ev(1, 4); tick();
    ev(2, 4); tick();
    ev(3, 4, 1, 1); tick();
    chk("col_nomatch", 32'(match_o), 0);
    chk("col_idle", 32'(busy_o[4]), 0);
    timeout_i = 8'd3;
    ev(0, 4); tick();
    ev(1, 4); tick();
    ev(2, 4); tick();
    tick(); tick();
    ev(3, 4); tick();
    chk("exp_match", 32'(match_o), 32'h10);
    chk("exp_noviol", 32'(violation_o), 0);

    // out-of-range lane field is ignored
    timeout_i = 8'd0;
    ev(0, 6); tick();
    chk("oor_busy", 32'(busy_o), 0);

    // counter saturation
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFE;
    seq(3);
    chk("sat1", 32'(match_count_o), 32'hFFFF);
    seq(0);
    chk("sat2", 32'(match_count_o), 32'hFFFF);

    // enable low mid-sequence
    ev(0, 2); tick();
    ev(1, 2); tick();
    enable_i = 1'b0;
    ev(2, 2); tick();
    chk("en_busy", 32'(busy_o), 0);
    chk("en_cnt", 32'(match_count_o), 32'hFFFF);
    enable_i = 1'b1;
    seq(2);
    chk("en_rematch", 32'(match_o), 32'h04);

    // async reset mid-sequence
    ev(0, 1); tick();
    ev(1, 1); tick();
    rst_ni = 1'b0;
    #1;
    m_clear();
    m_cnt = 0;
    chk("ar_busy", 32'(busy_o), 0);
    chk("ar_cnt", 32'(match_count_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seq(1);
    chk("ar_rematch", 32'(match_o), 32'h02);
    chk("ar_cnt2", 32'(match_count_o), 1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0)
        timeout_i = 8'($urandom_range(0, 6));
      enable_i = ($urandom_range(0, 59) != 0);
      for (int k = 0; k < NE; k++) begin
        lc[k].probe_val  = ($urandom_range(0, 1) == 1);
        lc[k].lane       = 3'($urandom_range(0, 7));
        lc[k].reset_lane = ($urandom_range(0, 29) == 0);
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
